// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared RAM and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              InstrRead;
    logic [15:0]       InstrAddr;
    logic              InstrWaitreq;
    logic              InstrValid;
    logic [DATA_W-1:0] InstrRdData;

    logic              ReadData;
    logic              WriteData;
    logic [15:0]       DataAddr;
    logic [DATA_W-1:0] DataOut;
    logic              DataWaitreq;
    logic              DataValid;
    logic [DATA_W-1:0] DataRdData;

    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWrData;
    logic              MemWren;
    logic [DATA_W-1:0] MemQ;

    modport slave (
        input  InstrRead, InstrAddr, ReadData, WriteData, DataAddr, DataOut, MemQ,
        output InstrWaitreq, InstrValid, InstrRdData, DataWaitreq, DataValid, DataRdData,
        output MemAddr, MemWrData, MemWren
    );

    modport master (
        output InstrRead, InstrAddr, ReadData, WriteData, DataAddr, DataOut, MemQ,
        input  InstrWaitreq, InstrValid, InstrRdData, DataWaitreq, DataValid, DataRdData,
        input  MemAddr, MemWrData, MemWren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data ports.
// Data wins by default; a saturating starvation counter periodically forces a fetch through.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam int unsigned TAG_I = 1;
    localparam int unsigned TAG_D = 0;

    logic [CNT_W-1:0]             r_starve_cnt;
    logic [ADDR_W-1:0]            r_mem_addr;
    logic [MEM_LATENCY-1:0][1:0]  r_tag;

    logic              w_dreq;
    logic              w_force;
    logic              w_grant_i;
    logic              w_grant_d;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [1:0]        w_tag_in;

    // Reset suppresses both grants so every asserted request sees a wait-request.
    always_comb begin
        w_dreq    = bus.ReadData | bus.WriteData;
        w_force   = (STARVE_LIMIT != 0) && (r_starve_cnt == CNT_MAX);
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!Reset) begin
            if (bus.InstrRead && (!w_dreq || w_force)) begin
                w_grant_i = 1'b1;
            end else if (w_dreq) begin
                w_grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_mem_addr = r_mem_addr;
        if (w_grant_i) begin
            w_mem_addr = bus.InstrAddr[ADDR_W-1:0];
        end else if (w_grant_d) begin
            w_mem_addr = bus.DataAddr[ADDR_W-1:0];
        end
        w_tag_in        = 2'b00;
        w_tag_in[TAG_I] = w_grant_i;
        w_tag_in[TAG_D] = w_grant_d & ~bus.WriteData;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
            r_tag        <= '0;
        end else begin
            if (w_grant_i || !bus.InstrRead) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && (r_starve_cnt != CNT_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            r_mem_addr <= w_mem_addr;
            r_tag[0]   <= w_tag_in;
            for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign bus.InstrWaitreq = bus.InstrRead & ~w_grant_i;
    assign bus.DataWaitreq  = w_dreq & ~w_grant_d;
    assign bus.MemAddr      = w_mem_addr;
    assign bus.MemWrData    = bus.DataOut;
    assign bus.MemWren      = w_grant_d & bus.WriteData;
    assign bus.InstrValid   = r_tag[MEM_LATENCY-1][TAG_I];
    assign bus.DataValid    = r_tag[MEM_LATENCY-1][TAG_D];
    assign bus.InstrRdData  = bus.MemQ;
    assign bus.DataRdData   = bus.MemQ;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 / limit 4, latency 2 / limit 2)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  = 1'b1;
    logic          ir   = 1'b0;
    logic [15:0]   ia   = '0;
    logic          rdr  = 1'b0;
    logic          wrr  = 1'b0;
    logic [15:0]   da   = '0;
    logic [DW-1:0] dout = '0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();

    logic [DW-1:0] q1;
    logic [DW-1:0] q2a;
    logic [DW-1:0] q2b;

    assign if1.InstrRead = ir;
    assign if1.InstrAddr = ia;
    assign if1.ReadData  = rdr;
    assign if1.WriteData = wrr;
    assign if1.DataAddr  = da;
    assign if1.DataOut   = dout;
    assign if1.MemQ      = q1;
    assign if2.InstrRead = ir;
    assign if2.InstrAddr = ia;
    assign if2.ReadData  = rdr;
    assign if2.WriteData = wrr;
    assign if2.DataAddr  = da;
    assign if2.DataOut   = dout;
    assign if2.MemQ      = q2b;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
        .Clock (clk),
        .Reset (rst),
        .bus   (if1)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2), .STARVE_LIMIT(2)) u_dut2 (
        .Clock (clk),
        .Reset (rst),
        .bus   (if2)
    );

    function automatic logic [15:0] init_word(input int unsigned a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    // RAM models: sample the port mid-cycle, act on the rising edge.
    logic [DW-1:0] ram1 [4096];
    logic [DW-1:0] ram2 [4096];

    initial begin
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] wd;
        for (int i = 0; i < 4096; i++) ram1[i] = init_word(i);
        q1 = '0;
        forever begin
            @(negedge clk);
            a  = if1.MemAddr;
            we = if1.MemWren;
            wd = if1.MemWrData;
            @(posedge clk);
            q1 = ram1[a];
            if (we) ram1[a] = wd;
        end
    end

    initial begin
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] wd;
        for (int i = 0; i < 4096; i++) ram2[i] = init_word(i);
        q2a = '0;
        q2b = '0;
        forever begin
            @(negedge clk);
            a  = if2.MemAddr;
            we = if2.MemWren;
            wd = if2.MemWrData;
            @(posedge clk);
            q2b = q2a;
            q2a = ram2[a];
            if (we) ram2[a] = wd;
        end
    end

    // Reference model state
    typedef struct {
        int          d;
        int unsigned due;
        bit          is_i;
        logic [15:0] data;
    } rd_t;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          starve [2];
    logic [11:0] last_addr [2];
    logic [15:0] ref_mem [2][4096];
    rd_t         pend [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_dut(input int d, input logic iw, input logic dw, input logic wren,
                             input logic [11:0] maddr, input logic [15:0] mwd,
                             input logic iv, input logic [15:0] ird,
                             input logic dv, input logic [15:0] drd);
        int          lim;
        int unsigned lat;
        bit          dreq, frc, gi, gd, eiv, edv;
        logic [11:0] ea;
        logic [15:0] eid, edd;
        rd_t         keep [$];
        rd_t         e;
        string       p;
        lim  = (d == 0) ? 4 : 2;
        lat  = (d == 0) ? 1 : 2;
        p    = $sformatf("dut%0d", d + 1);
        dreq = rdr || wrr;
        frc  = (lim != 0) && (starve[d] == lim);
        gi   = !rst && ir && (!dreq || frc);
        gd   = !rst && !gi && dreq;
        ea   = gi ? ia[11:0] : (gd ? da[11:0] : last_addr[d]);
        eiv  = 1'b0;
        edv  = 1'b0;
        eid  = '0;
        edd  = '0;
        foreach (pend[k]) begin
            if (pend[k].d == d && pend[k].due == cyc) begin
                if (pend[k].is_i) begin
                    eiv = 1'b1;
                    eid = pend[k].data;
                end else begin
                    edv = 1'b1;
                    edd = pend[k].data;
                end
            end
        end
        chk($sformatf("%s_instr_waitreq", p), 32'(iw), 32'(ir && !gi));
        chk($sformatf("%s_data_waitreq", p), 32'(dw), 32'(dreq && !gd));
        chk($sformatf("%s_mem_wren", p), 32'(wren), 32'(gd && wrr));
        chk($sformatf("%s_mem_addr", p), 32'(maddr), 32'(ea));
        if (gd && wrr) chk($sformatf("%s_mem_wrdata", p), 32'(mwd), 32'(dout));
        chk($sformatf("%s_instr_valid", p), 32'(iv), 32'(eiv));
        chk($sformatf("%s_data_valid", p), 32'(dv), 32'(edv));
        if (eiv) chk($sformatf("%s_instr_rddata", p), 32'(ird), 32'(eid));
        if (edv) chk($sformatf("%s_data_rddata", p), 32'(drd), 32'(edd));

        if (gd && wrr) ref_mem[d][da[11:0]] = dout;
        foreach (pend[k]) begin
            if (!(pend[k].d == d && (pend[k].due <= cyc || rst))) keep.push_back(pend[k]);
        end
        pend = keep;
        if (gi) begin
            e = '{d, cyc + lat, 1'b1, ref_mem[d][ia[11:0]]};
            pend.push_back(e);
        end
        if (gd && !wrr) begin
            e = '{d, cyc + lat, 1'b0, ref_mem[d][da[11:0]]};
            pend.push_back(e);
        end
        if (rst || gi || !ir) starve[d] = 0;
        else if (starve[d] < lim) starve[d]++;
        if (rst) last_addr[d] = '0;
        else if (gi || gd) last_addr[d] = ea;
    endtask

    task automatic step(input logic r, input logic i_r, input logic [15:0] i_a,
                        input logic d_r, input logic d_w, input logic [15:0] d_a,
                        input logic [15:0] d_o);
        @(posedge clk);
        #1;
        rst  = r;
        ir   = i_r;
        ia   = i_a;
        rdr  = d_r;
        wrr  = d_w;
        da   = d_a;
        dout = d_o;
        #3;
        model_dut(0, if1.InstrWaitreq, if1.DataWaitreq, if1.MemWren, if1.MemAddr,
                  if1.MemWrData, if1.InstrValid, if1.InstrRdData, if1.DataValid, if1.DataRdData);
        model_dut(1, if2.InstrWaitreq, if2.DataWaitreq, if2.MemWren, if2.MemAddr,
                  if2.MemWrData, if2.InstrValid, if2.InstrRdData, if2.DataValid, if2.DataRdData);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            starve[d]    = 0;
            last_addr[d] = '0;
            for (int i = 0; i < 4096; i++) ref_mem[d][i] = init_word(i);
        end

        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'h5555);
        chk("reset_instr_waitreq", 32'(if1.InstrWaitreq), 32'd1);
        chk("reset_data_waitreq", 32'(if1.DataWaitreq), 32'd1);
        chk("reset_mem_wren", 32'(if1.MemWren), 32'd0);
        chk("reset_instr_valid", 32'(if1.InstrValid), 32'd0);

        // Seed RAM[0x010] with 0xA5A5, then a lone fetch of it
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'hA5A5);
        chk("seed_wren", 32'(if1.MemWren), 32'd1);
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("lone_fetch_waitreq", 32'(if1.InstrWaitreq), 32'd0);
        idle();
        chk("lone_fetch_valid", 32'(if1.InstrValid), 32'd1);
        chk("lone_fetch_data", 32'(if1.InstrRdData), 32'hA5A5);
        chk("lone_fetch_no_dvalid", 32'(if1.DataValid), 32'd0);

        // Simultaneous fetch and data read: data first, fetch next cycle
        step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0020, 16'h0);
        chk("simul_data_waitreq", 32'(if1.DataWaitreq), 32'd0);
        chk("simul_instr_waitreq", 32'(if1.InstrWaitreq), 32'd1);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("simul_instr_accept", 32'(if1.InstrWaitreq), 32'd0);
        chk("simul_dvalid", 32'(if1.DataValid), 32'd1);
        idle();
        chk("simul_ivalid", 32'(if1.InstrValid), 32'd1);

        // Write then read-after-write
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0030, 16'h1234);
        chk("wr_wren", 32'(if1.MemWren), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0);
        chk("rd_wren_low", 32'(if1.MemWren), 32'd0);
        idle();
        chk("raw_dvalid", 32'(if1.DataValid), 32'd1);
        chk("raw_data", 32'(if1.DataRdData), 32'h1234);

        // Read and write together: write wins, no read result
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
        chk("both_wren", 32'(if1.MemWren), 32'd1);
        idle();
        chk("both_no_dvalid", 32'(if1.DataValid), 32'd0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle();
        chk("both_read_back", 32'(if1.DataRdData), 32'hBEEF);

        // Starvation: period 5 for limit 4, period 3 for limit 2
        idle();
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, 16'(16'h0100 + k), 1'b1, 1'b0, 16'h0200, 16'h0);
            chk("starve_d1_iwait", 32'(if1.InstrWaitreq), 32'((k % 5) != 4));
            chk("starve_d1_dwait", 32'(if1.DataWaitreq), 32'((k % 5) == 4));
            chk("starve_d2_iwait", 32'(if2.InstrWaitreq), 32'((k % 3) != 2));
        end

        // Reset mid-flight on the latency-2 instance
        idle();
        idle();
        idle();
        step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 16'h0006, 1'b0, 1'b1, 16'h0007, 16'h0001);
        chk("midrst_iwait", 32'(if2.InstrWaitreq), 32'd1);
        chk("midrst_dwait", 32'(if2.DataWaitreq), 32'd1);
        chk("midrst_wren", 32'(if2.MemWren), 32'd0);
        idle();
        chk("midrst_no_ivalid_a", 32'(if2.InstrValid), 32'd0);
        idle();
        chk("midrst_no_ivalid_b", 32'(if2.InstrValid), 32'd0);
        step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0);
        idle();
        idle();
        chk("postrst_ivalid", 32'(if2.InstrValid), 32'd1);
        chk("postrst_idata", 32'(if2.InstrRdData), 32'(init_word(5)));

        // Randomized traffic, all checked by the reference model
        for (int n = 0; n < 2000; n++) begin
            logic          r_r, r_ir, r_rd, r_wr;
            logic [15:0]   r_ia, r_da, r_do;
            r_r  = ($urandom % 64) == 0;
            r_ir = ($urandom % 4) != 0;
            r_rd = ($urandom % 3) == 0;
            r_wr = ($urandom % 5) == 0;
            r_ia = {4'($urandom), 7'h0, 5'($urandom)};
            r_da = {4'($urandom), 7'h0, 5'($urandom)};
            r_do = 16'($urandom);
            step(r_r, r_ir, r_ia, r_rd, r_wr, r_da, r_do);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the processor's instruction-fetch port and data port.
- Typical use: a single 4K x 16 memory holding both code and data.
- Grants at most one access per cycle and drives per-port wait-requests.
- Tracks in-flight reads so returned data is flagged to the correct requester.
- Data port has priority; a starvation counter bounds the instruction stall.

Parameters:
ADDR_W, 12, memory address width; requester addresses are truncated to [ADDR_W-1:0]
DATA_W, 16, word width
MEM_LATENCY, 1, cycles from address to valid MemQ (legal values: 1 or 2)
STARVE_LIMIT, 4, consecutive denied instruction cycles before instruction is forced to win; 0 = never force (pure data priority)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high
InstrRead  in  1  instruction fetch request
InstrAddr  in  16  fetch address
InstrWaitreq  out  1  1 = fetch not accepted this cycle, hold request
InstrValid  out  1  InstrRdData holds the fetch result this cycle
InstrRdData  out  DATA_W  fetch data (wired to MemQ)
ReadData  in  1  data read request
WriteData  in  1  data write request
DataAddr  in  16  data address
DataOut  in  DATA_W  write data
DataWaitreq  out  1  1 = data request not accepted this cycle
DataValid  out  1  DataRdData holds the read result this cycle
DataRdData  out  DATA_W  read data (wired to MemQ)
MemAddr  out  ADDR_W  RAM address
MemWrData  out  DATA_W  RAM write data
MemWren  out  1  RAM write enable
MemQ  in  DATA_W  RAM read data, valid MEM_LATENCY cycles after address

Behaviour:
- Acceptance rule: a request is accepted in a cycle where it is asserted and its Waitreq=0. Waitreqs are combinational from current requests and starve_cnt.
- Data request (dreq) = ReadData | WriteData. If both are high, the access is a write and the read is ignored: no DataValid.
- Grant, each cycle:
  - force = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - If InstrRead && (!dreq || force): grant instruction.
  - Else if dreq: grant data.
  - Else: idle.
- Waitreqs: InstrWaitreq = InstrRead && !grant_i. DataWaitreq = dreq && !grant_d. A non-requesting port sees Waitreq=0.
- Memory drive:
  - Instruction grant: MemAddr=InstrAddr[ADDR_W-1:0], MemWren=0.
  - Data grant: MemAddr=DataAddr[ADDR_W-1:0], MemWren=WriteData, MemWrData=DataOut.
  - Idle: MemAddr holds its last value, MemWren=0.
- starve_cnt (registered, saturating at STARVE_LIMIT):
  - Increments when InstrRead && grant_d.
  - Clears when grant_i or !InstrRead.
- Read tag pipeline: MEM_LATENCY stages of 2-bit tags {I,D}.
  - Stage 0 loads I on grant_i, D on a granted data read, and 00 otherwise (writes, idle).
  - InstrValid and DataValid are the I and D bits of the final stage, registered.
- Latency: a read accepted in cycle N returns data with Valid in cycle N+MEM_LATENCY. Back-to-back accepted reads give one result per cycle, in order.
- Writes complete in the accept cycle. A read of the same address in the next cycle returns the new value (RAM read-after-write).
- Reset (synchronous):
  - Clears starve_cnt, all tag stages, MemAddr, InstrValid and DataValid.
  - While Reset=1: both Waitreqs = 1 for any asserted request, MemWren=0.
  - Reset mid-operation discards in-flight reads; no Valid is asserted in the cycles after reset deasserts for reads issued before it.
- No other state; no back-pressure on read return (requesters must always accept Valid data).

Test Plan:
- Lone fetch: InstrRead=1, InstrAddr=0x0010, RAM[0x010]=0xA5A5 -> InstrWaitreq=0 at cycle N; InstrValid=1, InstrRdData=0xA5A5 at N+1; DataValid stays 0.
- Simultaneous requests: InstrRead=1 @0x0001, ReadData=1 @0x0020 in the same cycle -> DataWaitreq=0, InstrWaitreq=1; next cycle fetch is granted; DataValid at N+1 and InstrValid at N+2.
- Starvation, STARVE_LIMIT=4: ReadData held high every cycle with InstrRead=1 -> InstrWaitreq=1 for cycles 0..3; at cycle 4 InstrWaitreq=0 and DataWaitreq=1; pattern repeats every 5 cycles.
- Write then read: WriteData=1, DataAddr=0x0030, DataOut=0x1234, then ReadData @0x0030 -> MemWren=1 for one cycle; read returns 0x1234 with DataValid one cycle after its acceptance.
- WriteData and ReadData both high @0x0040 with DataOut=0xBEEF -> write performed, no DataValid; subsequent read of 0x0040 returns 0xBEEF.
- Reset mid-flight, MEM_LATENCY=2: accept a fetch, assert Reset the next cycle -> no InstrValid afterwards; during Reset both Waitreqs=1 for asserted requests and MemWren=0; the first fetch after reset returns normally.
